conv_layer_ctrl: RTL
====================

Name: conv_layer_ctrl

Overview:
Sequencer for one convolution layer built around a single conv_unit datapath instance. On a start pulse it runs one pass per output channel. Each pass:
- loads that channel's kernel, bias and shift;
- streams the full single-channel input feature map from feature memory into the conv unit;
- collects the OUT_SIZE*OUT_SIZE valid results into output memory.
It sits between the feature/weight memories and the conv unit, and reports busy/done/err to the network-level scheduler.

Parameters:
N, 8, data bit width of pixels and results
INPUT_SIZE, 28, input feature map side length
KERNEL_SIZE, 3, kernel side length
STRIDE, 1, convolution stride; OUT_SIZE = (INPUT_SIZE-KERNEL_SIZE)/STRIDE+1
OUT_CH, 6, number of output channels (kernels) processed sequentially
ADDR_W, 16, feature/output memory address width
DRAIN_TIMEOUT, 1024, max cycles in DRAIN without a conv_dout_vld before err

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle start request, honoured only in IDLE
busy  out  1  high from the cycle after accepted start until DONE exits
done  out  1  one-cycle pulse when all channels are complete
err  out  1  sticky drain-timeout flag; cleared by rst or the next accepted start
fm_rd_en  out  1  feature memory read enable; data returns 1 cycle later
fm_rd_addr  out  ADDR_W  feature memory read address, raster order from 0
wt_rd_en  out  1  weight/bias/shift memory read enable; memory holds data until the next read
wt_rd_addr  out  8  output channel index to fetch (0..OUT_CH-1)
conv_ce  out  1  conv unit enable, high while busy
conv_rst_n  out  1  conv unit reset (active low), pulsed low 1 cycle between channels
conv_input_vld  out  1  fm_rd_en delayed by exactly 1 cycle
conv_dout  in  N  conv unit result
conv_dout_vld  in  1  conv unit result valid
out_wr_en  out  1  output memory write enable
out_wr_addr  out  ADDR_W  oc*OUT_SIZE*OUT_SIZE + result index
out_wr_data  out  N  result data

Behaviour:
- Reset values:
  - low: busy, done, err, fm_rd_en, wt_rd_en, conv_ce, conv_input_vld, out_wr_en;
  - zero: all addresses, out_wr_data, all counters;
  - conv_rst_n=0 while rst is high; state=IDLE.
- FSM states: IDLE, CLR, LOAD, STREAM, DRAIN, NEXT, DONE.
- IDLE: waits for start.
  - start=1: oc<=0, err<=0 -> CLR.
- CLR: 1 cycle; conv_rst_n=0 -> LOAD.
- LOAD: 2 cycles.
  - Cycle 1: wt_rd_en=1, wt_rd_addr=oc.
  - Cycle 2: wait for the data to settle.
  - -> STREAM.
- STREAM: fm_rd_en=1 for exactly INPUT_SIZE*INPUT_SIZE consecutive cycles, addresses 0..INPUT_SIZE^2-1.
  - conv_input_vld follows fm_rd_en one cycle later.
  - -> DRAIN after the last address is issued.
- Result collection (active in STREAM and DRAIN): each conv_dout_vld=1 cycle:
  - registers conv_dout onto out_wr_data with out_wr_en=1 one cycle later;
  - address = oc*OUT_SIZE^2 + res_cnt, then res_cnt increments.
  - Write latency is 1 cycle.
  - Results past OUT_SIZE^2 in one channel are dropped (no write).
- DRAIN: exits when res_cnt==OUT_SIZE^2 (counting the write issued this cycle) -> NEXT.
  - idle_cnt resets on each conv_dout_vld.
  - If idle_cnt reaches DRAIN_TIMEOUT: err<=1 -> DONE, skipping remaining channels.
- NEXT: 1 cycle; conv_rst_n=0; res_cnt<=0.
  - oc==OUT_CH-1 -> DONE.
  - Otherwise oc<=oc+1 -> LOAD.
- DONE: 1 cycle; done=1; busy low next cycle -> IDLE.
- busy=1 in every state except IDLE. conv_ce=busy.
- start while busy: ignored, with no effect on counters or err.
- start in the same cycle as rst: rst wins.
- rst asserted mid-pass:
  - next cycle is in reset state;
  - no further out_wr_en;
  - conv_rst_n low for the whole reset.
- conv_rst_n is otherwise high.
- Address arithmetic is unsigned modulo 2^ADDR_W. OUT_CH*OUT_SIZE^2 must fit ADDR_W (design-time rule).

Test Plan:
1. INPUT_SIZE=6, K=3, STRIDE=1, OUT_CH=2; start; model returns 16 results per channel -> 32 writes at addresses 0..31 in order, data matching the model; single done pulse; busy high throughout; err=0.
2. Same config -> fm_rd_en high exactly 36 consecutive cycles per channel, addresses 0..35; conv_input_vld is fm_rd_en delayed 1 cycle; wt_rd_addr=0 then 1; conv_rst_n low 1 cycle in CLR and in NEXT.
3. Model withholds all results for channel 1, DRAIN_TIMEOUT=20 -> err=1 twenty cycles into DRAIN; done pulses; no writes for channel 1; next start clears err.
4. Model emits 18 results for channel 0 -> only 16 writes (addresses 0..15); channel 1 writes start at address 16.
5. start pulsed during STREAM and during DONE -> no restart; counters unchanged; exactly one done per accepted start.
6. rst asserted for 1 cycle midway through channel 0 STREAM -> all outputs at reset values next cycle; IDLE; a subsequent start completes a full clean run as in test 1.

Source files
------------

// File: rtl/conv_layer_ctrl.sv
// Convolution layer sequencer: runs one pass per output channel through a
// shared conv unit, streaming the feature map and collecting results.
module conv_layer_ctrl #(
  parameter int N             = 8,
  parameter int INPUT_SIZE    = 28,
  parameter int KERNEL_SIZE   = 3,
  parameter int STRIDE        = 1,
  parameter int OUT_CH        = 6,
  parameter int ADDR_W        = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              fm_rd_en,
  output logic [ADDR_W-1:0] fm_rd_addr,
  output logic              wt_rd_en,
  output logic [7:0]        wt_rd_addr,
  output logic              conv_ce,
  output logic              conv_rst_n,
  output logic              conv_input_vld,
  input  logic [N-1:0]      conv_dout,
  input  logic              conv_dout_vld,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [N-1:0]      out_wr_data
);

  localparam int OUT_SIZE = (INPUT_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int OSZ2     = OUT_SIZE * OUT_SIZE;
  localparam int PIX      = INPUT_SIZE * INPUT_SIZE;
  localparam int IW       = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX - 1);
  localparam logic [ADDR_W-1:0] RES_MAX  = ADDR_W'(OSZ2);
  localparam logic [IW-1:0]     TMO_LAST = IW'(DRAIN_TIMEOUT - 1);
  localparam logic [7:0]        OC_LAST  = 8'(OUT_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    STREAM,
    DRAIN,
    NEXT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0]        oc;
  logic              load_cyc;
  logic [ADDR_W-1:0] fm_cnt;
  logic [ADDR_W-1:0] res_cnt;
  logic [ADDR_W-1:0] res_nx;
  logic [ADDR_W-1:0] base;
  logic [IW-1:0]     idle_cnt;
  logic              take;
  logic              timeout;

  // A result is only accepted while collecting and below the channel quota
  always_comb begin
    take = 1'b0;
    if (state == STREAM || state == DRAIN)
      take = conv_dout_vld && (res_cnt < RES_MAX);
    res_nx  = res_cnt + {{(ADDR_W-1){1'b0}}, take};
    timeout = (state == DRAIN) && !conv_dout_vld
              && (idle_cnt == TMO_LAST);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = CLR;
      CLR:    state_nx = LOAD;
      LOAD:   if (load_cyc) state_nx = STREAM;
      STREAM: if (fm_cnt == PIX_LAST) state_nx = DRAIN;
      DRAIN: begin
        if (res_nx == RES_MAX) state_nx = NEXT;
        else if (timeout)      state_nx = DONE;
      end
      NEXT:   state_nx = (oc == OC_LAST) ? DONE : LOAD;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign conv_ce    = busy;
  assign done       = (state == DONE);
  assign fm_rd_en   = (state == STREAM);
  assign fm_rd_addr = fm_cnt;
  assign wt_rd_en   = (state == LOAD) && !load_cyc;
  assign wt_rd_addr = oc;
  assign conv_rst_n = !(rst || state == CLR || state == NEXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      oc             <= '0;
      load_cyc       <= 1'b0;
      fm_cnt         <= '0;
      res_cnt        <= '0;
      base           <= '0;
      idle_cnt       <= '0;
      err            <= 1'b0;
      conv_input_vld <= 1'b0;
      out_wr_en      <= 1'b0;
      out_wr_addr    <= '0;
      out_wr_data    <= '0;
    end else begin
      state          <= state_nx;
      conv_input_vld <= fm_rd_en;
      out_wr_en      <= take;
      if (take) begin
        out_wr_addr <= base + res_cnt;
        out_wr_data <= conv_dout;
      end
      res_cnt  <= res_nx;
      load_cyc <= (state == LOAD) && !load_cyc;
      if (fm_rd_en)
        fm_cnt <= (fm_cnt == PIX_LAST) ? '0 : fm_cnt + 1'b1;
      if (state == DRAIN && !conv_dout_vld)
        idle_cnt <= idle_cnt + 1'b1;
      else
        idle_cnt <= '0;
      if (timeout)
        err <= 1'b1;
      if (state == IDLE && start) begin
        oc      <= '0;
        err     <= 1'b0;
        base    <= '0;
        res_cnt <= '0;
      end
      if (state == NEXT) begin
        res_cnt <= '0;
        if (oc != OC_LAST) begin
          oc   <= oc + 1'b1;
          base <= base + RES_MAX;
        end
      end
    end
  end

endmodule
